// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the ALU execution units: issues one command, holds the
// selected unit enable for UNIT_LAT cycles, captures the result and returns it.
module alu_cmd_sequencer #(
    parameter int WIDTH    = 4,
    parameter int UNIT_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_fun,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [1:0]           ALU_FUN,
    output logic                 Arith_Enable,
    output logic                 Logic_Enable,
    output logic                 CMP_Enable,
    output logic                 Shift_Enable,
    input  logic [2*WIDTH-1:0]   Arith_OUT,
    input  logic [WIDTH-1:0]     Logic_OUT,
    input  logic [WIDTH-1:0]     CMP_OUT,
    input  logic [WIDTH-1:0]     Shift_OUT,
    input  logic                 Arith_Flag,
    input  logic                 Logic_Flag,
    input  logic                 CMP_Flag,
    input  logic                 Shift_Flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_err
);

    localparam int CW = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       count;
    logic [3:0]          fun_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                err;
    logic [2*WIDTH-1:0]  sel_out;
    logic                sel_flag;

    // Result and flag of the unit addressed by the latched command.
    always_comb begin
        sel_out  = '0;
        sel_flag = 1'b0;
        case (fun_q[3:2])
            2'b00: begin
                sel_out  = Arith_OUT;
                sel_flag = Arith_Flag;
            end
            2'b01: begin
                sel_out  = {{WIDTH{1'b0}}, Logic_OUT};
                sel_flag = Logic_Flag;
            end
            2'b10: begin
                sel_out  = {{WIDTH{1'b0}}, CMP_OUT};
                sel_flag = CMP_Flag;
            end
            default: begin
                sel_out  = {{WIDTH{1'b0}}, Shift_OUT};
                sel_flag = Shift_Flag;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            count    <= '0;
            fun_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            err      <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        fun_q <= cmd_fun;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                EXEC: begin
                    err <= err | ~sel_flag;
                    if (count != LAST) begin
                        count <= count + 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_data <= sel_out;
                    rsp_err  <= err;
                end
                RESP: begin
                    // Clear everything on completion so IDLE drives zeros to the units.
                    if (rsp_ready) begin
                        err      <= 1'b0;
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                        fun_q    <= '0;
                        a_q      <= '0;
                        b_q      <= '0;
                    end
                end
                default: begin
                    err <= err;
                end
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        A            = '0;
        B            = '0;
        ALU_FUN      = 2'b00;
        Arith_Enable = 1'b0;
        Logic_Enable = 1'b0;
        CMP_Enable   = 1'b0;
        Shift_Enable = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                A       = a_q;
                B       = b_q;
                ALU_FUN = fun_q[1:0];
                case (fun_q[3:2])
                    2'b00:   Arith_Enable = 1'b1;
                    2'b01:   Logic_Enable = 1'b1;
                    2'b10:   CMP_Enable   = 1'b1;
                    default: Shift_Enable = 1'b1;
                endcase
                if (count == LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                A          = a_q;
                B          = b_q;
                ALU_FUN    = fun_q[1:0];
                state_next = RESP;
            end
            RESP: begin
                A         = a_q;
                B         = b_q;
                ALU_FUN   = fun_q[1:0];
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer; a second instance with
// UNIT_LAT=3 covers the longer execute window.
module tb_alu_cmd_sequencer;

    logic        CLK;
    logic        RST;
    logic        cmd_valid, cmd_valid2;
    logic [3:0]  cmd_fun;
    logic [3:0]  cmd_a, cmd_b;
    logic        rsp_ready, rsp_ready2;
    logic [7:0]  Arith_OUT;
    logic [3:0]  Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    logic        cmd_ready, cmd_ready2;
    logic [3:0]  A, B, A2, B2;
    logic [1:0]  ALU_FUN, ALU_FUN2;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic        Arith_Enable2, Logic_Enable2, CMP_Enable2, Shift_Enable2;
    logic        rsp_valid, rsp_valid2;
    logic [7:0]  rsp_data, rsp_data2;
    logic        rsp_err, rsp_err2;

    logic [3:0]  en, en2;
    assign en  = {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable};
    assign en2 = {Arith_Enable2, Logic_Enable2, CMP_Enable2, Shift_Enable2};

    int errors = 0;
    int checks = 0;

    alu_cmd_sequencer #(.WIDTH(4), .UNIT_LAT(1)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    alu_cmd_sequencer #(.WIDTH(4), .UNIT_LAT(3)) dut_lat3 (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_fun(cmd_fun),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .A(A2), .B(B2), .ALU_FUN(ALU_FUN2),
        .Arith_Enable(Arith_Enable2), .Logic_Enable(Logic_Enable2),
        .CMP_Enable(CMP_Enable2), .Shift_Enable(Shift_Enable2),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_err(rsp_err2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        cmd_valid = 1'b1;
        cmd_fun = 4'b0100;
        cmd_a = 4'h1;
        cmd_b = 4'h2;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
            checks++; if (en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_enables: got %b want 0000", en); end
            checks++; if (A !== 4'h0 || rsp_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_outputs: A=%h rsp_data=%h want 0/00", A, rsp_data); end
        end
        cmd_valid = 1'b0;
        RST = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b1 || en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_no_accept: cmd_ready=%b en=%b want 1/0000", cmd_ready, en); end
    endtask

    task automatic test_logic_and();
        cmd_fun = 4'b0100;
        cmd_a = 4'hC;
        cmd_b = 4'hA;
        rsp_ready = 1'b1;
        Logic_OUT = 4'h8;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_a = 4'hF;
        cmd_fun = 4'b1111;
        checks++; if (en !== 4'b0100) begin errors++; $display("[TB] FAIL and_enable: got %b want 0100", en); end
        checks++; if (ALU_FUN !== 2'b00 || A !== 4'hC || B !== 4'hA) begin errors++; $display("[TB] FAIL and_operands: fun=%b A=%h B=%h want 00/C/A", ALU_FUN, A, B); end
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL and_exec_hs: cmd_ready=%b rsp_valid=%b want 0/0", cmd_ready, rsp_valid); end
        step();
        checks++; if (en !== 4'b0000 || rsp_valid !== 1'b0 || A !== 4'hC) begin errors++; $display("[TB] FAIL and_capture: en=%b rsp_valid=%b A=%h want 0000/0/C", en, rsp_valid, A); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL and_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 8'h08 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL and_rsp_data: data=%h err=%b want 08/0", rsp_data, rsp_err); end
        step();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || A !== 4'h0) begin errors++; $display("[TB] FAIL and_done: rsp_valid=%b cmd_ready=%b A=%h want 0/1/0", rsp_valid, cmd_ready, A); end
    endtask

    task automatic test_back_to_back();
        cmd_fun = 4'b0010;
        cmd_a = 4'h3;
        cmd_b = 4'h5;
        Arith_OUT = 8'h0F;
        CMP_OUT = 4'h3;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        step();
        checks++; if (en !== 4'b1000 || ALU_FUN !== 2'b10) begin errors++; $display("[TB] FAIL arith_enable: en=%b fun=%b want 1000/10", en, ALU_FUN); end
        cmd_fun = 4'b1000;
        cmd_a = 4'h2;
        cmd_b = 4'h2;
        step();
        checks++; if (ALU_FUN !== 2'b10 || A !== 4'h3 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL arith_capture: fun=%b A=%h cmd_ready=%b want 10/3/0", ALU_FUN, A, cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h0F) begin errors++; $display("[TB] FAIL arith_hold%0d: valid=%b data=%h want 1/0F", i, rsp_valid, rsp_data); end
            checks++; if (cmd_ready !== 1'b0 || en !== 4'b0000) begin errors++; $display("[TB] FAIL arith_block%0d: cmd_ready=%b en=%b want 0/0000", i, cmd_ready, en); end
        end
        rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || en !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_complete: valid=%b cmd_ready=%b en=%b want 0/1/0000", rsp_valid, cmd_ready, en); end
        step();
        cmd_valid = 1'b0;
        checks++; if (en !== 4'b0010 || ALU_FUN !== 2'b00 || A !== 4'h2) begin errors++; $display("[TB] FAIL cmp_enable: en=%b fun=%b A=%h want 0010/00/2", en, ALU_FUN, A); end
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL cmp_rsp: valid=%b data=%h err=%b want 1/03/0", rsp_valid, rsp_data, rsp_err); end
        step();
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL cmp_done: valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_flag_error();
        cmd_fun = 4'b0101;
        cmd_a = 4'h6;
        cmd_b = 4'h1;
        Logic_OUT = 4'h7;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        Logic_Flag = 1'b0;
        step();
        Logic_Flag = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h07 || rsp_err !== 1'b1) begin errors++; $display("[TB] FAIL flag_err: valid=%b data=%h err=%b want 1/07/1", rsp_valid, rsp_data, rsp_err); end
        step();
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL flag_clear: valid=%b err=%b want 1/0", rsp_valid, rsp_err); end
        step();
    endtask

    task automatic test_unit_lat3();
        logic [3:0] exp_en;
        logic       exp_valid;
        cmd_fun = 4'b1101;
        cmd_a = 4'h4;
        cmd_b = 4'h1;
        Shift_OUT = 4'h9;
        rsp_ready2 = 1'b1;
        cmd_valid2 = 1'b1;
        step();
        cmd_valid2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_en = (k < 3) ? 4'b0001 : 4'b0000;
            exp_valid = (k == 4);
            checks++; if (en2 !== exp_en || rsp_valid2 !== exp_valid) begin errors++; $display("[TB] FAIL lat3_cycle%0d: en=%b valid=%b want %b/%b", k, en2, rsp_valid2, exp_en, exp_valid); end
            if (k < 4) step();
        end
        checks++; if (rsp_data2 !== 8'h09 || ALU_FUN2 !== 2'b01) begin errors++; $display("[TB] FAIL lat3_data: data=%h fun=%b want 09/01", rsp_data2, ALU_FUN2); end
        step();
        checks++; if (cmd_ready2 !== 1'b1 || rsp_valid2 !== 1'b0) begin errors++; $display("[TB] FAIL lat3_done: cmd_ready=%b valid=%b want 1/0", cmd_ready2, rsp_valid2); end
    endtask

    task automatic test_reset_in_exec();
        cmd_fun = 4'b0011;
        cmd_a = 4'h9;
        cmd_b = 4'h9;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++; if (en !== 4'b1000) begin errors++; $display("[TB] FAIL rexec_enable: got %b want 1000", en); end
        RST = 1'b0;
        step();
        RST = 1'b1;
        checks++; if (cmd_ready !== 1'b1 || en !== 4'b0000 || A !== 4'h0 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rexec_idle: cmd_ready=%b en=%b A=%h valid=%b want 1/0000/0/0", cmd_ready, en, A, rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rexec_silent%0d: valid=%b cmd_ready=%b want 0/1", i, rsp_valid, cmd_ready); end
        end
    endtask

    initial begin
        RST = 1'b0;
        cmd_valid = 1'b0;
        cmd_valid2 = 1'b0;
        cmd_fun = 4'h0;
        cmd_a = 4'h0;
        cmd_b = 4'h0;
        rsp_ready = 1'b0;
        rsp_ready2 = 1'b0;
        Arith_OUT = 8'hA5;
        Logic_OUT = 4'h8;
        CMP_OUT = 4'h3;
        Shift_OUT = 4'h9;
        Arith_Flag = 1'b1;
        Logic_Flag = 1'b1;
        CMP_Flag = 1'b1;
        Shift_Flag = 1'b1;
        #2;
        test_reset();
        test_logic_and();
        test_back_to_back();
        test_flag_error();
        test_unit_lat3();
        test_reset_in_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
